// File: rtl/pipe_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_seq_pkg
// Description : Shared types and constants for the pipeline stall/flush
//               sequencer (state encoding, stall counts, register match).
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STALL    = 2'd2,
        ST_MEM_WAIT = 2'd3
    } seq_state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam logic [1:0] STALL_NONE  = 2'd0;
    localparam logic [1:0] STALL_LU    = 2'd1;
    localparam logic [1:0] STALL_BR_LD = 2'd2;

    localparam int unsigned CNT_W_DEF       = 32;
    localparam int unsigned MEM_TIMEOUT_DEF = 64;

    // $0 is hard-wired, so writing it can never create a dependency.
    function automatic logic reg_match(
        input logic [4:0] dst,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return (dst != REG_ZERO) && ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use / branch-operand hazard detection;
//               reports how many stall cycles the ID instruction needs.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipe_seq_pkg::*;
(
    input  logic [4:0] ifid_rs_i,
    input  logic [4:0] ifid_rt_i,
    input  logic       ifid_uses_rt_i,
    input  logic       ifid_branch_i,
    input  logic       idex_memread_i,
    input  logic       idex_regwrite_i,
    input  logic [4:0] idex_dst_i,
    input  logic       exmem_memread_i,
    input  logic [4:0] exmem_dst_i,
    output logic [1:0] stall_need_o
);

    logic w_ex_match;
    logic w_mem_match;

    assign w_ex_match  = reg_match(idex_dst_i,  ifid_rs_i, ifid_rt_i, ifid_uses_rt_i);
    assign w_mem_match = reg_match(exmem_dst_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i);

    // Branches resolve in ID, so they also wait for ALU results in EX and
    // for load data still in MEM.
    always_comb begin
        stall_need_o = STALL_NONE;
        if (idex_memread_i && w_ex_match && ifid_branch_i) begin
            stall_need_o = STALL_BR_LD;
        end else if ((idex_memread_i && w_ex_match && !ifid_branch_i) ||
                     (ifid_branch_i && idex_regwrite_i && !idex_memread_i && w_ex_match) ||
                     (ifid_branch_i && exmem_memread_i && w_mem_match)) begin
            stall_need_o = STALL_LU;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_sequencer
// Description : Stall/flush/hold sequencer for the 5-stage MIPS pipeline.
//               Optional perf counters enabled by macro PIPE_SEQ_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_sequencer
    import pipe_seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             ifid_branch_i,
    input  logic             ifid_jump_i,
    input  logic             branch_taken_i,
    input  logic             idex_memread_i,
    input  logic             idex_regwrite_i,
    input  logic [4:0]       idex_dst_i,
    input  logic             exmem_memread_i,
    input  logic [4:0]       exmem_dst_i,
    input  logic             exmem_memaccess_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             bubble_o,
    output logic             pipe_hold_o,
    output logic             timeout_o
`ifdef PIPE_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    localparam int unsigned       c_TO_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(MEM_TIMEOUT);

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    seq_state_e        r_ret_state;
    seq_state_e        w_ret_state_nxt;
    seq_state_e        w_eff_state;
    logic [1:0]        r_stall_cnt;
    logic [1:0]        w_stall_cnt_nxt;
    logic [1:0]        w_stall_need;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [c_TO_W-1:0] w_to_inc;
    logic              r_timeout;
    logic              w_hold;

    hazard_detect u_hazard_detect (
        .ifid_rs_i       (ifid_rs_i),
        .ifid_rt_i       (ifid_rt_i),
        .ifid_uses_rt_i  (ifid_uses_rt_i),
        .ifid_branch_i   (ifid_branch_i),
        .idex_memread_i  (idex_memread_i),
        .idex_regwrite_i (idex_regwrite_i),
        .idex_dst_i      (idex_dst_i),
        .exmem_memread_i (exmem_memread_i),
        .exmem_dst_i     (exmem_dst_i),
        .stall_need_o    (w_stall_need)
    );

    // A pending memory access without ack freezes everything, ahead of any
    // hazard stall; the ack cycle behaves as the interrupted state would.
    assign w_hold = (r_state == ST_MEM_WAIT) ? !dmem_ack_i
                  : ((r_state != ST_IDLE) && exmem_memaccess_i && !dmem_ack_i);
    assign w_eff_state = (r_state == ST_MEM_WAIT) ? r_ret_state : r_state;
    assign w_to_inc    = r_to_cnt + 1'b1;

    always_comb begin
        w_state_nxt     = r_state;
        w_ret_state_nxt = r_ret_state;
        w_stall_cnt_nxt = r_stall_cnt;
        pc_write_o      = 1'b0;
        ifid_write_o    = 1'b0;
        ifid_flush_o    = 1'b0;
        bubble_o        = 1'b0;
        pipe_hold_o     = 1'b0;

        if (r_state == ST_IDLE) begin
            bubble_o = 1'b1;
            if (start_i) begin
                w_state_nxt = ST_RUN;
            end
        end else if (w_hold) begin
            pipe_hold_o = 1'b1;
            if (r_state != ST_MEM_WAIT) begin
                w_ret_state_nxt = r_state;
                w_state_nxt     = ST_MEM_WAIT;
            end
        end else begin
            case (w_eff_state)
                ST_RUN: begin
                    if (w_stall_need != STALL_NONE) begin
                        bubble_o        = 1'b1;
                        w_stall_cnt_nxt = w_stall_need - 2'd1;
                        w_state_nxt     = (w_stall_need > 2'd1) ? ST_STALL : ST_RUN;
                    end else begin
                        pc_write_o   = 1'b1;
                        ifid_write_o = 1'b1;
                        ifid_flush_o = ifid_jump_i | (ifid_branch_i & branch_taken_i);
                        w_state_nxt  = ST_RUN;
                    end
                end
                ST_STALL: begin
                    bubble_o = 1'b1;
                    if (r_stall_cnt > 2'd1) begin
                        w_stall_cnt_nxt = r_stall_cnt - 2'd1;
                        w_state_nxt     = ST_STALL;
                    end else begin
                        w_stall_cnt_nxt = 2'd0;
                        w_state_nxt     = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_ret_state <= ST_IDLE;
            r_stall_cnt <= 2'd0;
            r_to_cnt    <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret_state <= w_ret_state_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
            if (r_state == ST_MEM_WAIT) begin
                if (dmem_ack_i) begin
                    r_to_cnt <= '0;
                end else if (r_to_cnt != c_TO_MAX) begin
                    r_to_cnt <= w_to_inc;
                    if (w_to_inc == c_TO_MAX) begin
                        r_timeout <= 1'b1;
                    end
                end
            end
        end
    end

    assign timeout_o = r_timeout;

`ifdef PIPE_SEQ_PERF_EN
    logic [CNT_W-1:0] r_perf_stall;
    logic [CNT_W-1:0] r_perf_flush;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if ((r_state != ST_IDLE) && !pc_write_o && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
            if (ifid_flush_o && (r_perf_flush != '1)) begin
                r_perf_flush <= r_perf_flush + 1'b1;
            end
        end
    end

    assign stall_cnt_o = r_perf_stall;
    assign flush_cnt_o = r_perf_flush;
`else
    // CNT_W only sizes the perf counters, which this build leaves out.
    if (CNT_W < 1) begin : g_no_perf
    end
`endif

endmodule
`default_nettype wire

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Stall/flush sequencer for the 5-stage MIPS pipeline. Sits beside the main decode control unit. Detects load-use and branch-operand hazards, and holds the pipeline while the data memory is waiting for an acknowledge. Drives the PC write enable, the IF/ID write and flush, and the bubble select that zeroes the WB/MEM/EX control bundles going into ID/EX.

## Interface
- MEM_TIMEOUT, 64: MEM_WAIT cycle count at which `timeout_o` sets.
- CNT_W, 32: width of the performance counters.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  run enable; sampled only in IDLE.
- ifid_rs_i  in  5  rs field of the instruction in ID.
- ifid_rt_i  in  5  rt field of the instruction in ID.
- ifid_uses_rt_i  in  1  rt is a source (R-type, beq, sw).
- ifid_branch_i  in  1  beq in ID.
- ifid_jump_i  in  1  j in ID.
- branch_taken_i  in  1  ID comparator result; valid only when ifid_branch_i=1.
- idex_memread_i  in  1  lw in EX.
- idex_regwrite_i  in  1  EX instruction writes a register.
- idex_dst_i  in  5  EX destination register, after the RegDst mux.
- exmem_memread_i  in  1  lw in MEM.
- exmem_dst_i  in  5  MEM destination register.
- exmem_memaccess_i  in  1  lw or sw in MEM.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC load enable.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  IF/ID loads a NOP.
- bubble_o  out  1  FlushMUX select; zeroes the ID/EX control bundle.
- pipe_hold_o  out  1  freezes ID/EX, EX/MEM and MEM/WB.
- timeout_o  out  1  sticky memory-timeout flag.
- stall_cnt_o  out  CNT_W  stall cycles; only with PIPE_SEQ_PERF_EN.
- flush_cnt_o  out  CNT_W  flush cycles; only with PIPE_SEQ_PERF_EN.

## Operation
- FSM states: IDLE, RUN, STALL, MEM_WAIT. Registers: state, a 2-bit stall counter, a return-state register, the timeout counter and the timeout flag.
- match(d) = (d != 0) && (d == rs || (ifid_uses_rt_i && d == rt)). Register 0 never causes a hazard.
- Required stall count N, evaluated in RUN:
  - N=2: idex_memread_i, match(idex_dst_i) and ifid_branch_i.
  - N=1: any of
    - idex_memread_i and match(idex_dst_i), non-branch;
    - ifid_branch_i, idex_regwrite_i, !idex_memread_i and match(idex_dst_i);
    - ifid_branch_i, exmem_memread_i and match(exmem_dst_i).
  - N=0: otherwise.
- Stall cycle outputs: pc_write_o=0, ifid_write_o=0, bubble_o=1, ifid_flush_o=0.
- RUN:
  - N>0: stall cycle; load counter with N-1; go to STALL if N-1>0, else stay in RUN.
  - N=0: pc_write_o=1, ifid_write_o=1, bubble_o=0.
  - Flush only when N=0: ifid_flush_o = ifid_jump_i | (ifid_branch_i & branch_taken_i).
- STALL: stall cycle; decrement the counter; return to RUN once it reaches 0. No flush is raised in STALL.
- Memory wait has priority over everything else:
  - Trigger: in RUN or STALL, exmem_memaccess_i=1 and dmem_ack_i=0.
  - Every cycle the trigger holds, or the FSM is in MEM_WAIT without ack: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, bubble_o=0, ifid_flush_o=0.
  - On the trigger: save RUN/STALL in the return-state register, enter MEM_WAIT, and leave the stall counter unchanged.
- MEM_WAIT:
  - Timeout counter increments every cycle, saturating. At MEM_TIMEOUT, timeout_o sets and stays set until reset; the wait continues.
  - On the dmem_ack_i=1 cycle: pipe_hold_o=0, outputs are computed as in the saved state, the FSM transitions as that state would, and the timeout counter clears.
- IDLE: pc_write_o=0, ifid_write_o=0, bubble_o=1, pipe_hold_o=0. start_i=1 moves to RUN on the next cycle. start_i is ignored outside IDLE.

## Timing
- Reset values: state=IDLE, stall counter=0, timeout counter=0, timeout_o=0, perf counters=0.
- Outputs in the reset state: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, bubble_o=1, pipe_hold_o=0, timeout_o=0.
- All outputs except timeout_o and the counters are combinational from the current state and inputs (Mealy), with zero-cycle latency.
- Load-use stalls for exactly 1 cycle.
- Load feeding a branch stalls for exactly 2 consecutive cycles.
- rst_i mid-stall or mid-wait returns to IDLE on the next edge; the saved state is discarded.
- Ack arriving in the same cycle as the request: no hold and no MEM_WAIT entry.

## Configuration
- Macro: PIPE_SEQ_PERF_EN.
- Defined:
  - stall_cnt_o counts non-IDLE cycles with pc_write_o=0.
  - flush_cnt_o counts cycles with ifid_flush_o=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports and their counters are absent. All other behaviour is identical.

## Structure
- Package `pipe_seq_pkg`:
  - state enum;
  - REG_ZERO = 5'd0;
  - STALL_LU = 1, STALL_BR_LD = 2;
  - counter width constants.
- Sub-module `hazard_detect`: combinational match logic and N computation. The FSM and counters live in `pipeline_sequencer`.

## Test plan
- Load-use: lw to $8 in EX, add reading $8 in ID.
  - Expect pc_write_o=0 and bubble_o=1 for 1 cycle, then RUN resumes.
- Branch after load: lw to $9 in EX, beq on $9 in ID, taken.
  - Expect 2 stall cycles with ifid_flush_o=0.
  - Then 1 cycle with ifid_flush_o=1.
- $0 destination: lw $0 in EX, add reads $0.
  - Expect no stall.
- Memory wait: lw in MEM, dmem_ack_i low for 3 cycles.
  - Expect pipe_hold_o=1 for 3 cycles; released on the ack cycle.
  - Same with MEM_TIMEOUT=2: timeout_o set and stays set after the ack.
- Wait during STALL: wait starts during the first cycle of a 2-cycle stall.
  - Expect exactly 1 further stall cycle after the ack.
- Reset and perf:
  - Reset asserted in MEM_WAIT: IDLE outputs next cycle.
  - With PIPE_SEQ_PERF_EN, after one load-use stall and one jump: stall_cnt_o=1, flush_cnt_o=1.
